// File: rtl/calc2_req_sequencer.sv
// Request sequencer in front of one calc2 port pair: accepts whole operations,
// allocates 2-bit tags, drives the two-cycle request and returns completions/timeouts.
module calc2_req_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_cmd,
    input  logic [31:0] op_data1,
    input  logic [31:0] op_data2,
    output logic [3:0]  req_cmd,
    output logic [31:0] req_data,
    output logic [1:0]  req_tag,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    input  logic [1:0]  out_tag,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_tag,
    output logic [3:0]  busy_tags,
    output logic        err_unexp_tag,
    output logic        err_zero_cmd
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRV1 = 2'd1;
    localparam logic [1:0] ST_DRV2 = 2'd2;
    localparam logic [7:0] TMO_SAT = 8'(TIMEOUT_CYC);

    logic [1:0]  state_reg, state_next;
    logic [3:0]  cmd_reg;
    logic [31:0] data1_reg, data2_reg;
    logic [1:0]  tag_reg;
    logic [3:0]  busy_reg, busy_next;
    logic [7:0]  cnt_reg [4];
    logic [3:0]  tmo_pend;
    logic [3:0]  alloc_mask, free_mask;
    logic [1:0]  alloc_tag, tmo_tag;
    logic        accept, accept_op, rsp_hit, rsp_unexp;
    logic        comp_valid;
    logic [1:0]  comp_status, comp_tag;
    logic [31:0] comp_data;

    assign op_ready  = (state_reg == ST_IDLE || state_reg == ST_DRV2) && (busy_reg != 4'hF);
    assign accept    = op_valid && op_ready;
    assign accept_op = accept && (op_cmd != 4'd0);
    assign busy_tags = busy_reg;

    // Lowest free tag, judged on the registered busy set so a tag freed this edge is not reused yet
    always_comb begin
        alloc_tag = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!busy_reg[i]) alloc_tag = 2'(i);
        end
        alloc_mask = accept_op ? (4'b0001 << alloc_tag) : 4'b0000;
    end

    always_comb begin
        tmo_tag = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (tmo_pend[i]) tmo_tag = 2'(i);
        end
    end

    // A tag becomes timeout-pending on the edge its counter would reach the limit
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tmo
            assign tmo_pend[gi] = busy_reg[gi] &&
                                  (({1'b0, cnt_reg[gi]} + 9'd1) >= {1'b0, TMO_SAT});

            always_ff @(posedge c_clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg[gi] <= 8'd0;
                end else if (alloc_mask[gi] || free_mask[gi]) begin
                    cnt_reg[gi] <= 8'd0;
                end else if (busy_reg[gi] && cnt_reg[gi] != TMO_SAT) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 8'd1;
                end
            end
        end
    endgenerate

    // Matching calc2 response wins the completion slot; timeouts wait for a free cycle
    always_comb begin
        rsp_hit     = (out_resp != 2'd0) && busy_reg[out_tag];
        rsp_unexp   = (out_resp != 2'd0) && !busy_reg[out_tag];
        comp_valid  = 1'b0;
        comp_status = 2'd0;
        comp_data   = 32'd0;
        comp_tag    = 2'd0;
        free_mask   = 4'b0000;
        if (rsp_hit) begin
            comp_valid  = 1'b1;
            comp_status = (out_resp == 2'd3) ? 2'd2 : out_resp;
            comp_data   = out_data;
            comp_tag    = out_tag;
            free_mask   = 4'b0001 << out_tag;
        end else if (|tmo_pend) begin
            comp_valid  = 1'b1;
            comp_status = 2'd3;
            comp_tag    = tmo_tag;
            free_mask   = 4'b0001 << tmo_tag;
        end
        busy_next = (busy_reg & ~free_mask) | alloc_mask;
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE: state_next = accept_op ? ST_DRV1 : ST_IDLE;
            ST_DRV1: state_next = ST_DRV2;
            ST_DRV2: state_next = accept_op ? ST_DRV1 : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_cmd  = 4'd0;
        req_data = 32'd0;
        req_tag  = 2'd0;
        case (state_reg)
            ST_DRV1: begin
                req_cmd  = cmd_reg;
                req_data = data1_reg;
                req_tag  = tag_reg;
            end
            ST_DRV2: begin
                req_data = data2_reg;
                req_tag  = tag_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cmd_reg       <= 4'd0;
            data1_reg     <= 32'd0;
            data2_reg     <= 32'd0;
            tag_reg       <= 2'd0;
            busy_reg      <= 4'd0;
            rsp_valid     <= 1'b0;
            rsp_status    <= 2'd0;
            rsp_data      <= 32'd0;
            rsp_tag       <= 2'd0;
            err_unexp_tag <= 1'b0;
            err_zero_cmd  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            busy_reg      <= busy_next;
            rsp_valid     <= comp_valid;
            rsp_status    <= comp_status;
            rsp_data      <= comp_data;
            rsp_tag       <= comp_tag;
            err_unexp_tag <= rsp_unexp;
            err_zero_cmd  <= accept && (op_cmd == 4'd0);
            if (accept_op) begin
                cmd_reg   <= op_cmd;
                data1_reg <= op_data1;
                data2_reg <= op_data2;
                tag_reg   <= alloc_tag;
            end
        end
    end

endmodule

// File: tb/tb_calc2_req_sequencer.sv
// Scoreboard bench for calc2_req_sequencer: a deadline-based reference model queues
// expected completions/pulses; a negedge monitor pops and compares against the DUT.
module tb_calc2_req_sequencer;

    localparam int TMO = 8;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_cmd = '0;
    logic [31:0] op_data1 = '0, op_data2 = '0;
    logic [3:0]  req_cmd;
    logic [31:0] req_data;
    logic [1:0]  req_tag;
    logic [1:0]  out_resp = '0;
    logic [31:0] out_data = '0;
    logic [1:0]  out_tag = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_tag;
    logic [3:0]  busy_tags;
    logic        err_unexp_tag, err_zero_cmd;

    calc2_req_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .c_clk(c_clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
        .op_data1(op_data1), .op_data2(op_data2),
        .req_cmd(req_cmd), .req_data(req_data), .req_tag(req_tag),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .busy_tags(busy_tags),
        .err_unexp_tag(err_unexp_tag), .err_zero_cmd(err_zero_cmd)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        int          cyc;
        int          kind;   // 0 completion, 1 unexpected-tag pulse, 2 zero-cmd pulse
        logic [1:0]  st;
        logic [31:0] d;
        logic [1:0]  tg;
    } ev_t;

    ev_t evq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  run_chk = 0;

    // Reference state: which tags are outstanding and the cycle each becomes timeout-eligible
    bit          mdl_busy [4];
    int          deadline [4];
    int          last_acc = -10;
    logic [3:0]  l_cmd = '0;
    logic [31:0] l_d1 = '0, l_d2 = '0;
    logic [1:0]  l_tag = '0;

    function automatic int low_free();
        for (int i = 0; i < 4; i++) if (!mdl_busy[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] busy_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = mdl_busy[i];
        return v;
    endfunction

    // New op may start when the bus is not mid-request and a tag is free
    function automatic bit exp_ready();
        return (cyc != last_acc + 1) && (low_free() >= 0);
    endfunction

    function automatic void push_ev(int c, int k, logic [1:0] st, logic [31:0] d, logic [1:0] tg);
        ev_t e;
        e.cyc = c; e.kind = k; e.st = st; e.d = d; e.tg = tg;
        evq.push_back(e);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        evq.delete();
        for (int i = 0; i < 4; i++) begin
            mdl_busy[i] = 0;
            deadline[i] = 0;
        end
        last_acc = -10;
    endtask

    always @(posedge c_clk) begin
        if (reset) begin
            int  ft, freed;
            bit  acc;
            acc   = op_valid && exp_ready();
            ft    = low_free();
            freed = -1;
            if (out_resp != 2'd0) begin
                if (mdl_busy[out_tag]) begin
                    push_ev(cyc + 1, 0, (out_resp == 2'd3) ? 2'd2 : out_resp, out_data, out_tag);
                    freed = int'(out_tag);
                end else begin
                    push_ev(cyc + 1, 1, 2'd0, 32'd0, 2'd0);
                end
            end
            if (freed < 0) begin
                for (int i = 0; i < 4; i++) begin
                    if (freed < 0 && mdl_busy[i] && cyc >= deadline[i]) begin
                        push_ev(cyc + 1, 0, 2'd3, 32'd0, 2'(i));
                        freed = i;
                    end
                end
            end
            if (freed >= 0) mdl_busy[freed] = 0;
            if (acc) begin
                if (op_cmd == 4'd0) begin
                    push_ev(cyc + 1, 2, 2'd0, 32'd0, 2'd0);
                end else begin
                    mdl_busy[ft] = 1;
                    deadline[ft] = cyc + TMO;
                    last_acc     = cyc;
                    l_cmd = op_cmd; l_d1 = op_data1; l_d2 = op_data2; l_tag = 2'(ft);
                    $display("cyc %0d accept cmd=%0d d1=%h d2=%h tag=%0d", cyc, op_cmd, op_data1, op_data2, ft);
                end
            end
            cyc++;
        end
    end

    always @(negedge c_clk) begin
        if (reset && run_chk) begin
            ev_t         e;
            bit          er, eu, ez;
            logic [1:0]  es, et;
            logic [31:0] ed;
            logic [3:0]  xc;
            logic [31:0] xd;
            logic [1:0]  xt;
            er = 0; eu = 0; ez = 0; es = '0; et = '0; ed = '0;
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                case (e.kind)
                    0: begin er = 1; es = e.st; ed = e.d; et = e.tg; end
                    1: eu = 1;
                    default: ez = 1;
                endcase
            end
            xc = '0; xd = '0; xt = '0;
            if (cyc == last_acc + 1) begin
                xc = l_cmd; xd = l_d1; xt = l_tag;
            end else if (cyc == last_acc + 2) begin
                xd = l_d2; xt = l_tag;
            end
            chk("op_ready", 32'(op_ready), 32'(exp_ready()));
            chk("busy_tags", 32'(busy_tags), 32'(busy_vec()));
            chk("req_cmd", 32'(req_cmd), 32'(xc));
            chk("req_data", req_data, xd);
            chk("req_tag", 32'(req_tag), 32'(xt));
            chk("rsp_valid", 32'(rsp_valid), 32'(er));
            if (er && rsp_valid) begin
                chk("rsp_status", 32'(rsp_status), 32'(es));
                chk("rsp_data", rsp_data, ed);
                chk("rsp_tag", 32'(rsp_tag), 32'(et));
                $display("cyc %0d completion tag=%0d status=%0d data=%h", cyc, rsp_tag, rsp_status, rsp_data);
            end
            chk("err_unexp_tag", 32'(err_unexp_tag), 32'(eu));
            chk("err_zero_cmd", 32'(err_zero_cmd), 32'(ez));
        end
    end

    // One cycle of stimulus: set inputs at a negedge, hold until the next negedge
    task automatic step(logic v, logic [3:0] cmd, logic [31:0] d1, logic [31:0] d2,
                        logic [1:0] rs, logic [1:0] rt, logic [31:0] rd);
        op_valid = v; op_cmd = cmd; op_data1 = d1; op_data2 = d2;
        out_resp = rs; out_tag = rt; out_data = rd;
        @(negedge c_clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0);
    endtask

    initial begin
        logic [3:0] rc;
        int         rprob;
        model_clear();
        repeat (3) @(negedge c_clk);
        chk("reset_busy", 32'(busy_tags), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        run_chk = 1;

        // single add, response 0x50 on tag 0
        step(1, 4'd1, 32'h30, 32'h20, 2'd0, 2'd0, 32'd0);
        idle(2);
        step(0, 4'd0, 32'd0, 32'd0, 2'd1, 2'd0, 32'h50);
        idle(2);

        // fill all four tags, free tag 2 and reuse it
        for (int i = 0; i < 8; i++) step(1, 4'd2, 32'(100 + i), 32'(200 + i), 2'd0, 2'd0, 32'd0);
        step(0, 4'd0, 32'd0, 32'd0, 2'd1, 2'd2, 32'hAAAA0002);
        step(1, 4'd5, 32'h11, 32'h3, 2'd0, 2'd0, 32'd0);
        idle(2);

        // out-of-order responses then a new op takes tag 0
        step(0, 4'd0, 32'd0, 32'd0, 2'd1, 2'd1, 32'hBBBB0001);
        step(0, 4'd0, 32'd0, 32'd0, 2'd3, 2'd0, 32'hBBBB0000);
        step(1, 4'd6, 32'h80, 32'h2, 2'd0, 2'd0, 32'd0);
        idle(TMO + 6);

        // timeout followed by a late response for the freed tag, plus a zero-cmd drop
        step(1, 4'd1, 32'h5, 32'h6, 2'd0, 2'd0, 32'd0);
        idle(TMO + 2);
        step(0, 4'd0, 32'd0, 32'd0, 2'd1, 2'd0, 32'h1234);
        step(1, 4'd0, 32'h9, 32'h9, 2'd0, 2'd0, 32'd0);
        idle(2);

        // tag 0 timeout-pending in the same cycle a tag 1 response arrives
        step(1, 4'd1, 32'h1, 32'h1, 2'd0, 2'd0, 32'd0);
        idle(1);
        step(1, 4'd2, 32'h2, 32'h2, 2'd0, 2'd0, 32'd0);
        idle(TMO - 3);
        step(0, 4'd0, 32'd0, 32'd0, 2'd1, 2'd1, 32'hCAFE);
        idle(3);

        // asynchronous reset in the middle of a request
        step(1, 4'd1, 32'hDEAD, 32'hBEEF, 2'd0, 2'd0, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_req_cmd", 32'(req_cmd), 32'd0);
        chk("async_req_data", req_data, 32'd0);
        chk("async_req_tag", 32'(req_tag), 32'd0);
        chk("async_busy", 32'(busy_tags), 32'd0);
        model_clear();
        @(negedge c_clk);
        @(negedge c_clk);
        reset = 1'b1;
        step(0, 4'd0, 32'd0, 32'd0, 2'd1, 2'd0, 32'h77);
        idle(2);

        // randomized traffic, first with frequent then with rare responses
        for (int n = 0; n < 3000; n++) begin
            rprob = (n < 1500) ? 3 : 12;
            case ($urandom_range(0, 9))
                0, 1:    rc = 4'd1;
                2, 3:    rc = 4'd2;
                4:       rc = 4'd5;
                5:       rc = 4'd6;
                6:       rc = 4'd0;
                default: rc = 4'($urandom);
            endcase
            step(($urandom_range(0, 9) < 7), rc, $urandom, $urandom,
                 (($urandom % rprob) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                 2'($urandom), $urandom);
        end
        idle(3 * TMO + 10);
        chk("queue_drained", 32'(evq.size()), 32'd0);
        chk("final_busy", 32'(busy_tags), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
